// File: rtl/sgn_result_pipe_pkg.sv
// Shared definitions for the FP add/subtract sign-resolution pipeline:
// rounding-mode codes, precision widths and the sign-table helper.
package sgn_result_pipe_pkg;

  localparam int unsigned W_SP = 32;
  localparam int unsigned W_DP = 64;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RTP = 2'b10;
  localparam logic [1:0] RM_RTN = 2'b11;

  typedef struct packed {
    logic sgn;
    logic swap;
    logic zero;
  } sgn_res_t;

  // An exact cancellation yields -0 only when rounding toward negative infinity.
  function automatic sgn_res_t resolve_sign(input logic gt, input logic eq,
                                            input logic sx, input logic sye,
                                            input logic rtn);
    sgn_res_t r;
    r = '0;
    if (gt) begin
      r.sgn = sx;
    end else if (!eq) begin
      r.sgn  = sye;
      r.swap = 1'b1;
    end else if (sx == sye) begin
      r.sgn = sx;
    end else begin
      r.zero = 1'b1;
      r.sgn  = rtn;
    end
    return r;
  endfunction

endpackage

// File: rtl/sgn_result_pipe_mag_cmp.sv
// Combinational unsigned magnitude comparator used by the sign-resolution stage.
module mag_cmp #(
  parameter int unsigned N = 31
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/sgn_result_pipe.sv
// Two-stage sign-resolution pipeline: magnitude compare, then the sign table,
// with valid/ready handshaking, synchronous flush and zero-gated outputs.
module sgn_result_pipe
  import sgn_result_pipe_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned RM_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            AddSubt_i,
  input  logic [W-1:0]    Data_X_i,
  input  logic [W-1:0]    Data_Y_i,
  input  logic [RM_W-1:0] rmode_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            sgn_result_o,
  output logic            swap_o,
  output logic            zero_o
);

  logic            r_s1_valid;
  logic            r_s2_valid;
  logic            r_s1_gt;
  logic            r_s1_eq;
  logic            r_s1_sx;
  logic            r_s1_sye;
  logic [RM_W-1:0] r_s1_rmode;
  sgn_res_t        r_s2_res;

  logic            w_gt;
  logic            w_eq;
  logic            w_s1_adv;
  logic            w_in_xfer;
  sgn_res_t        w_s2_next;

  mag_cmp #(.N(W-1)) u_mag_cmp (
    .a  (Data_X_i[W-2:0]),
    .b  (Data_Y_i[W-2:0]),
    .gt (w_gt),
    .eq (w_eq)
  );

  assign w_s1_adv  = ~r_s2_valid | ready_i;
  // Flush empties the pipe, so ready is advertised, but the operand is discarded.
  assign ready_o   = flush_i | ~r_s1_valid | w_s1_adv;
  assign w_in_xfer = valid_i & ready_o & ~flush_i;

  assign w_s2_next = resolve_sign(r_s1_gt, r_s1_eq, r_s1_sx, r_s1_sye,
                                  r_s1_rmode == RM_W'(RM_RTN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_in_xfer | (r_s1_valid & ~w_s1_adv);
      r_s2_valid <= w_s1_adv ? r_s1_valid : r_s2_valid;
    end
  end

  // Payload registers carry no reset; the outputs are gated by r_s2_valid instead.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_s1_gt    <= w_gt;
      r_s1_eq    <= w_eq;
      r_s1_sx    <= Data_X_i[W-1];
      r_s1_sye   <= Data_Y_i[W-1] ^ AddSubt_i;
      r_s1_rmode <= rmode_i;
    end
    if (r_s1_valid && w_s1_adv) begin
      r_s2_res <= w_s2_next;
    end
  end

  assign valid_o      = r_s2_valid;
  assign sgn_result_o = r_s2_valid & r_s2_res.sgn;
  assign swap_o       = r_s2_valid & r_s2_res.swap;
  assign zero_o       = r_s2_valid & r_s2_res.zero;

endmodule

// File: tb/tb_sgn_result_pipe.sv
// Scoreboard bench for sgn_result_pipe: single-precision instance for handshake
// scenarios, double-precision instance for the wide-operand cases.
module tb_sgn_result_pipe;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic        AddSubt_i;
  logic [31:0] Data_X_i;
  logic [31:0] Data_Y_i;
  logic [1:0]  rmode_i;
  logic        valid_o;
  logic        ready_i;
  logic        sgn_result_o;
  logic        swap_o;
  logic        zero_o;

  logic        d_flush;
  logic        d_valid_i;
  logic        d_ready_o;
  logic        d_addsub;
  logic [63:0] d_x;
  logic [63:0] d_y;
  logic [1:0]  d_rm;
  logic        d_valid_o;
  logic        d_ready_i;
  logic        d_sgn;
  logic        d_swap;
  logic        d_zero;

  int          checks;
  int          failures;
  int          n_out;
  logic [2:0]  sb_q[$];

  logic        stall_prev;
  logic        flush_prev;
  logic [3:0]  held;

  sgn_result_pipe #(.W(32), .RM_W(2)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .AddSubt_i    (AddSubt_i),
    .Data_X_i     (Data_X_i),
    .Data_Y_i     (Data_Y_i),
    .rmode_i      (rmode_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sgn_result_o (sgn_result_o),
    .swap_o       (swap_o),
    .zero_o       (zero_o)
  );

  sgn_result_pipe #(.W(64), .RM_W(2)) u_dut64 (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (d_flush),
    .valid_i      (d_valid_i),
    .ready_o      (d_ready_o),
    .AddSubt_i    (d_addsub),
    .Data_X_i     (d_x),
    .Data_Y_i     (d_y),
    .rmode_i      (d_rm),
    .valid_o      (d_valid_o),
    .ready_i      (d_ready_i),
    .sgn_result_o (d_sgn),
    .swap_o       (d_swap),
    .zero_o       (d_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sgn, swap, zero}
  function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y,
                                       input logic sub, input logic [1:0] rm);
    logic [30:0] mx;
    logic [30:0] my;
    logic        sx;
    logic        sy;
    mx = x[30:0];
    my = y[30:0];
    sx = x[31];
    sy = y[31] ^ sub;
    if (mx == my && sx != sy) return {(rm == 2'b11), 1'b0, 1'b1};
    if (my > mx)              return {sy, 1'b1, 1'b0};
    return {sx, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stall_prev && !flush_prev) begin
        checks++;
        if ({valid_o, sgn_result_o, swap_o, zero_o} !== held) begin
          failures++;
          $display("FAIL stall_stable got=%b want=%b", {valid_o, sgn_result_o, swap_o, zero_o}, held);
        end
      end
      if (valid_o === 1'b0) begin
        checks++;
        if ({sgn_result_o, swap_o, zero_o} !== 3'b000) begin
          failures++;
          $display("FAIL gated_idle got=%b want=000", {sgn_result_o, swap_o, zero_o});
        end
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        checks++;
        n_out++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out got=%b want=no output", {sgn_result_o, swap_o, zero_o});
        end else begin
          logic [2:0] e;
          e = sb_q.pop_front();
          if ({sgn_result_o, swap_o, zero_o} !== e) begin
            failures++;
            $display("FAIL result got=%b want=%b", {sgn_result_o, swap_o, zero_o}, e);
          end
        end
      end
      stall_prev = (valid_o === 1'b1) && (ready_i === 1'b0);
      held       = {valid_o, sgn_result_o, swap_o, zero_o};
      flush_prev = flush_i;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic sub, input logic [1:0] rm);
    int unsigned n;
    bit          done;
    n = 0;
    done = 1'b0;
    valid_i = 1'b1; Data_X_i = x; Data_Y_i = y; AddSubt_i = sub; rmode_i = rm;
    while (!done) begin
      @(negedge clk);
      if (ready_o === 1'b1 && flush_i === 1'b0) begin
        sb_q.push_back(model(x, y, sub, rm));
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 60) begin
        checks++; failures++;
        $display("FAIL send_timeout got=ready_o low want=accept within 60 cycles");
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((sb_q.size() != 0 || valid_o === 1'b1) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d pending want=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid_o, sgn_result_o, swap_o, zero_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {valid_o, sgn_result_o, swap_o, zero_o});
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", ready_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int unsigned lat;
    ready_i = 1'b1;
    send(32'h40400000, 32'hC0000000, 1'b0, 2'b00);
    lat = 1;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=valid_o %b want=0", valid_o);
    end
    while (valid_o !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL latency got=%0d want=2", lat);
    end
    send(32'h3F800000, 32'h40000000, 1'b1, 2'b00);
    send(32'h41200000, 32'h41200000, 1'b1, 2'b00);
    send(32'h41200000, 32'h41200000, 1'b1, 2'b11);
    send(32'h41200000, 32'hC1200000, 1'b0, 2'b10);
    send(32'h80000000, 32'h80000000, 1'b0, 2'b11);
    drain("basic");
  endtask

  task automatic test_dp;
    logic [63:0] xs[2];
    logic [63:0] ys[2];
    logic        subs[2];
    logic [2:0]  want[2];
    int unsigned n;
    xs[0] = 64'h8000000000000000; ys[0] = 64'h8000000000000000; subs[0] = 1'b0; want[0] = 3'b100;
    xs[1] = 64'h3FF0000000000000; ys[1] = 64'h4000000000000000; subs[1] = 1'b1; want[1] = 3'b110;
    d_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_valid_i = 1'b1; d_x = xs[i]; d_y = ys[i]; d_addsub = subs[i]; d_rm = 2'b00;
      @(posedge clk); #1;
      d_valid_i = 1'b0;
      n = 0;
      while (d_valid_o !== 1'b1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if ({d_valid_o, d_sgn, d_swap, d_zero} !== {1'b1, want[i]}) begin
        failures++;
        $display("FAIL dp_case%0d got=%b want=%b", i, {d_valid_o, d_sgn, d_swap, d_zero}, {1'b1, want[i]});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int base;
    base = n_out;
    ready_i = 1'b1;
    fork
      begin
        send(32'h40000000, 32'h3F800000, 1'b0, 2'b00);
        send(32'h3F800000, 32'hC0000000, 1'b0, 2'b00);
        send(32'hC0400000, 32'h40400000, 1'b0, 2'b01);
        send(32'h40A00000, 32'h40A00000, 1'b1, 2'b11);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_full cycle=%0d got=%b want=0", k, ready_o);
          end
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_release got=%b want=1", ready_o);
        end
      end
    join
    drain("bp");
    checks++;
    if (n_out - base != 4) begin
      failures++;
      $display("FAIL bp_count got=%0d want=4", n_out - base);
    end
  endtask

  task automatic test_random;
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] x;
          logic [31:0] y;
          logic        s;
          x = $urandom;
          y = $urandom;
          s = $urandom_range(0, 1) == 1;
          if ($urandom_range(0, 2) == 0) y = {s, x[30:0]};
          send(x, y, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join
    ready_i = 1'b1;
    drain("random");
  endtask

  task automatic test_flush_reset;
    int base;
    ready_i = 1'b0;
    send(32'h40400000, 32'h3F800000, 1'b0, 2'b00);
    send(32'h3F800000, 32'h40400000, 1'b0, 2'b00);
    flush_i = 1'b1;
    valid_i = 1'b1; Data_X_i = 32'h40E00000; Data_Y_i = 32'h3F800000;
    @(negedge clk);
    checks++;
    if ({ready_o, valid_o} !== 2'b11) begin
      failures++;
      $display("FAIL flush_cycle got=%b want=11", {ready_o, valid_o});
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    sb_q.delete();
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL flush_after got=%b want=01", {valid_o, ready_o});
    end
    base = n_out;
    ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n_out != base) begin
      failures++;
      $display("FAIL flush_dropped got=%0d outputs want=0", n_out - base);
    end

    ready_i = 1'b0;
    send(32'h40400000, 32'hC0000000, 1'b0, 2'b00);
    send(32'h3F800000, 32'h40000000, 1'b1, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, sgn_result_o, swap_o, zero_o} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got=%b want=0000", {valid_o, sgn_result_o, swap_o, zero_o});
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    ready_i = 1'b1;
    base = n_out;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || n_out != base) begin
      failures++;
      $display("FAIL reset_release got=valid_o %b outputs %0d want=0 0", valid_o, n_out - base);
    end
    send(32'hC1200000, 32'h41200000, 1'b0, 2'b11);
    drain("post_reset");
    checks++;
    if (n_out - base != 1) begin
      failures++;
      $display("FAIL post_reset_count got=%0d want=1", n_out - base);
    end
  endtask

  initial begin
    checks = 0; failures = 0; n_out = 0;
    stall_prev = 1'b0; flush_prev = 1'b0; held = '0;
    rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    AddSubt_i = 1'b0; Data_X_i = '0; Data_Y_i = '0; rmode_i = '0;
    d_flush = 1'b0; d_valid_i = 1'b0; d_ready_i = 1'b1; d_addsub = 1'b0;
    d_x = '0; d_y = '0; d_rm = '0;
    #1;
    test_reset;
    test_basic;
    test_dp;
    test_backpressure;
    test_random;
    test_flush_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
